// File: rtl/axi_default_slave_pkg.sv
// Shared constants and FSM state types for the AXI default (DECERR) slave.
package axi_default_slave_pkg;

   localparam int ID_W_DEF   = 8;
   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int LEN_W_DEF  = 4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } w_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_e;

endpackage

// File: rtl/axi_defslv_errlog.sv
// Error logger for the default slave: remembers the last unmapped address
// and counts decode errors (saturating). Only built with AXI_DEFSLV_ERRLOG_EN.
`ifdef AXI_DEFSLV_ERRLOG_EN
module axi_defslv_errlog #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              aw_hs,
   input  logic              ar_hs,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic [ADDR_W-1:0] araddr,
   output logic [ADDR_W-1:0] err_addr,
   output logic [15:0]       err_cnt
);

   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic [15:0]       err_cnt_q, err_cnt_d;
   logic [1:0]        inc;
   logic [16:0]       sum;

   // Next log state: write address wins a same-cycle tie, count adds both.
   always_comb begin
      err_addr_d = err_addr_q;
      inc        = {1'b0, aw_hs} + {1'b0, ar_hs};
      sum        = {1'b0, err_cnt_q} + {15'd0, inc};
      if (aw_hs) begin
         err_addr_d = awaddr;
      end else if (ar_hs) begin
         err_addr_d = araddr;
      end
      err_cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
   end

   // Log registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_addr_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         err_addr_q <= err_addr_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign err_addr = err_addr_q;
   assign err_cnt  = err_cnt_q;

endmodule
`endif

// File: rtl/axi_default_slave.sv
// AXI default slave: accepts any burst routed to it and answers with DECERR.
// Independent write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_DATA) FSMs.
// Optional error log (ERR_ADDR/ERR_CNT) with macro AXI_DEFSLV_ERRLOG_EN.
// Handshake: a transfer happens on a rising edge where VALID and READY are
// both high; every output here is decoded from registers only.
module axi_default_slave
   import axi_default_slave_pkg::*;
#(
   parameter int ID_W   = ID_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic [ID_W-1:0]     AWID,
   input  logic [ADDR_W-1:0]   AWADDR,
   input  logic [LEN_W-1:0]    AWLEN,
   input  logic                AWVALID,
   output logic                AWREADY,
   input  logic [DATA_W-1:0]   WDATA,
   input  logic [DATA_W/8-1:0] WSTRB,
   input  logic                WLAST,
   input  logic                WVALID,
   output logic                WREADY,
   output logic [ID_W-1:0]     BID,
   output logic [1:0]          BRESP,
   output logic                BVALID,
   input  logic                BREADY,
   input  logic [ID_W-1:0]     ARID,
   input  logic [ADDR_W-1:0]   ARADDR,
   input  logic [LEN_W-1:0]    ARLEN,
   input  logic                ARVALID,
   output logic                ARREADY,
   output logic [ID_W-1:0]     RID,
   output logic [DATA_W-1:0]   RDATA,
   output logic [1:0]          RRESP,
   output logic                RLAST,
   output logic                RVALID,
   input  logic                RREADY
`ifdef AXI_DEFSLV_ERRLOG_EN
   ,
   output logic [ADDR_W-1:0]   ERR_ADDR,
   output logic [15:0]         ERR_CNT
`endif
);

   localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

   w_state_e         w_state_q, w_state_d;
   logic [ID_W-1:0]  aw_id_q, aw_id_d;
   logic [LEN_W-1:0] aw_len_q, aw_len_d;
   logic [LEN_W-1:0] w_cnt_q, w_cnt_d;

   r_state_e         r_state_q, r_state_d;
   logic [ID_W-1:0]  ar_id_q, ar_id_d;
   logic [LEN_W-1:0] ar_len_q, ar_len_d;
   logic [LEN_W-1:0] r_cnt_q, r_cnt_d;

   // Write data is discarded; WLAST does not terminate the burst.
`ifdef AXI_DEFSLV_ERRLOG_EN
   logic unused_inputs;
   assign unused_inputs = ^{WDATA, WSTRB, WLAST};
`else
   logic unused_inputs;
   assign unused_inputs = ^{WDATA, WSTRB, WLAST, AWADDR, ARADDR};
`endif

   // Write FSM next state: count AWLEN+1 beats, then hold the response.
   always_comb begin
      w_state_d = w_state_q;
      aw_id_d   = aw_id_q;
      aw_len_d  = aw_len_q;
      w_cnt_d   = w_cnt_q;
      case (w_state_q)
         W_IDLE: begin
            if (AWVALID) begin
               aw_id_d   = AWID;
               aw_len_d  = AWLEN;
               w_cnt_d   = '0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (WVALID) begin
               if (w_cnt_q == aw_len_q) begin
                  w_state_d = W_RESP;
               end else begin
                  w_cnt_d = w_cnt_q + CNT_ONE;
               end
            end
         end
         W_RESP: begin
            if (BREADY) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Write channel outputs decoded from the registered write state.
   always_comb begin
      AWREADY = (w_state_q == W_IDLE);
      WREADY  = (w_state_q == W_DATA);
      BVALID  = (w_state_q == W_RESP);
      BID     = '0;
      BRESP   = RESP_OKAY;
      if (w_state_q == W_RESP) begin
         BID   = aw_id_q;
         BRESP = RESP_DECERR;
      end
   end

   // Write FSM registers.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state_q <= W_IDLE;
         aw_id_q   <= '0;
         aw_len_q  <= '0;
         w_cnt_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         aw_id_q   <= aw_id_d;
         aw_len_q  <= aw_len_d;
         w_cnt_q   <= w_cnt_d;
      end
   end

   // Read FSM next state: stream ARLEN+1 error beats, one per RREADY.
   always_comb begin
      r_state_d = r_state_q;
      ar_id_d   = ar_id_q;
      ar_len_d  = ar_len_q;
      r_cnt_d   = r_cnt_q;
      if (r_state_q == R_IDLE) begin
         if (ARVALID) begin
            ar_id_d   = ARID;
            ar_len_d  = ARLEN;
            r_cnt_d   = '0;
            r_state_d = R_DATA;
         end
      end else begin
         if (RREADY) begin
            if (r_cnt_q == ar_len_q) begin
               r_state_d = R_IDLE;
            end else begin
               r_cnt_d = r_cnt_q + CNT_ONE;
            end
         end
      end
   end

   // Read channel outputs decoded from the registered read state.
   always_comb begin
      ARREADY = (r_state_q == R_IDLE);
      RVALID  = (r_state_q == R_DATA);
      RID     = '0;
      RRESP   = RESP_OKAY;
      RLAST   = 1'b0;
      if (r_state_q == R_DATA) begin
         RID   = ar_id_q;
         RRESP = RESP_DECERR;
         RLAST = (r_cnt_q == ar_len_q);
      end
   end

   assign RDATA = '0;

   // Read FSM registers.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state_q <= R_IDLE;
         ar_id_q   <= '0;
         ar_len_q  <= '0;
         r_cnt_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         ar_id_q   <= ar_id_d;
         ar_len_q  <= ar_len_d;
         r_cnt_q   <= r_cnt_d;
      end
   end

`ifdef AXI_DEFSLV_ERRLOG_EN
   logic aw_hs, ar_hs;
   assign aw_hs = AWVALID && (w_state_q == W_IDLE);
   assign ar_hs = ARVALID && (r_state_q == R_IDLE);

   axi_defslv_errlog #(.ADDR_W(ADDR_W)) u_errlog (
      .clk      (ACLK),
      .rst      (ARESET),
      .aw_hs    (aw_hs),
      .ar_hs    (ar_hs),
      .awaddr   (AWADDR),
      .araddr   (ARADDR),
      .err_addr (ERR_ADDR),
      .err_cnt  (ERR_CNT)
   );
`endif

endmodule

// File: tb/tb_axi_default_slave.sv
// Bench for axi_default_slave: reset checks, a table of directed bursts,
// hand-written corner sequences and a randomized run against a queue model.
module tb_axi_default_slave;

   logic        aclk;
   logic        areset;
   logic [7:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [7:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [7:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic        arvalid;
   logic        arready;
   logic [7:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
`ifdef AXI_DEFSLV_ERRLOG_EN
   logic [31:0] err_addr;
   logic [15:0] err_cnt;
`endif

   int total = 0;
   int bad   = 0;

   int          exp_err_cnt  = 0;
   logic [31:0] exp_err_addr = '0;

   typedef struct {
      bit         is_wr;
      logic [7:0] id;
      logic [3:0] len;
      int         wlast_beat;
      int         stall;
      int         exp_beats;
      logic [1:0] exp_resp;
   } vec_t;

   typedef struct {
      logic [7:0] id;
      bit         last;
   } rbeat_t;

   vec_t vecs[7];

   axi_default_slave dut (
      .ACLK    (aclk),
      .ARESET  (areset),
      .AWID    (awid),
      .AWADDR  (awaddr),
      .AWLEN   (awlen),
      .AWVALID (awvalid),
      .AWREADY (awready),
      .WDATA   (wdata),
      .WSTRB   (wstrb),
      .WLAST   (wlast),
      .WVALID  (wvalid),
      .WREADY  (wready),
      .BID     (bid),
      .BRESP   (bresp),
      .BVALID  (bvalid),
      .BREADY  (bready),
      .ARID    (arid),
      .ARADDR  (araddr),
      .ARLEN   (arlen),
      .ARVALID (arvalid),
      .ARREADY (arready),
      .RID     (rid),
      .RDATA   (rdata),
      .RRESP   (rresp),
      .RLAST   (rlast),
      .RVALID  (rvalid),
      .RREADY  (rready)
`ifdef AXI_DEFSLV_ERRLOG_EN
      ,
      .ERR_ADDR(err_addr),
      .ERR_CNT (err_cnt)
`endif
   );

   // Clock and watchdog.
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk_errlog();
`ifdef AXI_DEFSLV_ERRLOG_EN
      chk("err_cnt", err_cnt, exp_err_cnt);
      chk("err_addr", err_addr, exp_err_addr);
`endif
   endtask

   task automatic do_reset();
      areset = 1'b1;
      tick();
      tick();
      areset = 1'b0;
      exp_err_cnt  = 0;
      exp_err_addr = '0;
   endtask

   task automatic do_write(input vec_t v);
      awid    = v.id;
      awlen   = v.len;
      awaddr  = $urandom;
      awvalid = 1'b1;
      chk("wr_awready", awready, 1);
      tick();
      awvalid = 1'b0;
      exp_err_cnt++;
      exp_err_addr = awaddr;
      chk_errlog();
      chk("wr_wready_lat", wready, 1);
      chk("wr_aw_busy", awready, 0);
      for (int b = 0; b < v.exp_beats; b++) begin
         wvalid = 1'b1;
         wdata  = $urandom;
         wstrb  = 4'hF;
         wlast  = (b == v.wlast_beat);
         chk("wr_wready", wready, 1);
         chk("wr_b_early", bvalid, 0);
         tick();
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      chk("wr_bvalid", bvalid, 1);
      chk("wr_bid", bid, v.id);
      chk("wr_bresp", bresp, v.exp_resp);
      chk("wr_wready_done", wready, 0);
      for (int s = 0; s < v.stall; s++) begin
         tick();
         chk("wr_bvalid_hold", bvalid, 1);
         chk("wr_bid_hold", bid, v.id);
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("wr_bvalid_clr", bvalid, 0);
      chk("wr_bid_idle", bid, 0);
      chk("wr_awready_back", awready, 1);
   endtask

   task automatic do_read(input vec_t v);
      int beat = 0;
      int cyc  = 0;
      arid    = v.id;
      arlen   = v.len;
      araddr  = $urandom;
      arvalid = 1'b1;
      chk("rd_arready", arready, 1);
      tick();
      arvalid = 1'b0;
      exp_err_cnt++;
      exp_err_addr = araddr;
      chk_errlog();
      chk("rd_rvalid_lat", rvalid, 1);
      chk("rd_ar_busy", arready, 0);
      while (beat < v.exp_beats && cyc < 64) begin
         rready = (v.stall != 0) ? ((cyc % 2) == 1) : 1'b1;
         chk("rd_rvalid", rvalid, 1);
         chk("rd_rid", rid, v.id);
         chk("rd_rdata", rdata, 0);
         chk("rd_rresp", rresp, v.exp_resp);
         chk("rd_rlast", rlast, (beat == v.exp_beats - 1));
         tick();
         if (rready) beat++;
         cyc++;
      end
      if (beat < v.exp_beats) chk("rd_timeout", beat, v.exp_beats);
      rready = 1'b0;
      chk("rd_rvalid_clr", rvalid, 0);
      chk("rd_rlast_idle", rlast, 0);
      chk("rd_rid_idle", rid, 0);
      chk("rd_arready_back", arready, 1);
   endtask

   // Randomized run against a transaction-level model.
   task automatic random_run(input int cycles);
      bit          wr_busy = 0;
      bit          b_pend  = 0;
      int          w_left  = 0;
      logic [7:0]  w_id    = '0;
      rbeat_t      r_q[$];
      bit          e_awready, e_wready, e_arready, e_rvalid;
      bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
      int          len;
      for (int c = 0; c < cycles; c++) begin
         awvalid = ($urandom_range(0, 2) == 0);
         awid    = $urandom;
         awlen   = 4'($urandom_range(0, 3));
         awaddr  = $urandom;
         wvalid  = $urandom_range(0, 1) == 1;
         wdata   = $urandom;
         wlast   = $urandom_range(0, 1) == 1;
         bready  = $urandom_range(0, 2) != 0;
         arvalid = ($urandom_range(0, 2) == 0);
         arid    = $urandom;
         arlen   = 4'($urandom_range(0, 3));
         araddr  = $urandom;
         rready  = $urandom_range(0, 2) != 0;

         e_awready = !wr_busy;
         e_wready  = wr_busy && (w_left > 0);
         e_arready = (r_q.size() == 0);
         e_rvalid  = (r_q.size() != 0);
         chk("rnd_awready", awready, e_awready);
         chk("rnd_wready", wready, e_wready);
         chk("rnd_bvalid", bvalid, b_pend);
         chk("rnd_bid", bid, b_pend ? w_id : 8'h00);
         chk("rnd_bresp", bresp, b_pend ? 2'b11 : 2'b00);
         chk("rnd_arready", arready, e_arready);
         chk("rnd_rvalid", rvalid, e_rvalid);
         chk("rnd_rid", rid, e_rvalid ? r_q[0].id : 8'h00);
         chk("rnd_rlast", rlast, e_rvalid ? r_q[0].last : 1'b0);
         chk("rnd_rresp", rresp, e_rvalid ? 2'b11 : 2'b00);
         chk("rnd_rdata", rdata, 0);
         chk_errlog();

         aw_hs = awvalid && e_awready;
         w_hs  = wvalid && e_wready;
         b_hs  = b_pend && bready;
         ar_hs = arvalid && e_arready;
         r_hs  = e_rvalid && rready;
         if (b_hs) begin
            b_pend  = 0;
            wr_busy = 0;
         end
         if (w_hs) begin
            w_left--;
            if (w_left == 0) b_pend = 1;
         end
         if (aw_hs) begin
            wr_busy = 1;
            w_left  = int'(awlen) + 1;
            w_id    = awid;
         end
         if (r_hs) void'(r_q.pop_front());
         if (ar_hs) begin
            len = int'(arlen);
            for (int i = 0; i <= len; i++) r_q.push_back('{id: arid, last: (i == len)});
         end
         exp_err_cnt = exp_err_cnt + int'(aw_hs) + int'(ar_hs);
         if (exp_err_cnt > 65535) exp_err_cnt = 65535;
         if (aw_hs) exp_err_addr = awaddr;
         else if (ar_hs) exp_err_addr = araddr;
         tick();
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      arvalid = 1'b0;
      rready  = 1'b0;
      bready  = 1'b0;
   endtask

   initial begin
      vec_t rv;
      logic [31:0] cc_awaddr;

      vecs[0] = '{is_wr: 1, id: 8'h15, len: 4'd0,  wlast_beat: 0,  stall: 0, exp_beats: 1,  exp_resp: 2'b11};
      vecs[1] = '{is_wr: 0, id: 8'h2A, len: 4'd3,  wlast_beat: 0,  stall: 0, exp_beats: 4,  exp_resp: 2'b11};
      vecs[2] = '{is_wr: 0, id: 8'h33, len: 4'd1,  wlast_beat: 0,  stall: 1, exp_beats: 2,  exp_resp: 2'b11};
      vecs[3] = '{is_wr: 1, id: 8'h44, len: 4'd1,  wlast_beat: 1,  stall: 5, exp_beats: 2,  exp_resp: 2'b11};
      vecs[4] = '{is_wr: 1, id: 8'h5A, len: 4'd2,  wlast_beat: 0,  stall: 0, exp_beats: 3,  exp_resp: 2'b11};
      vecs[5] = '{is_wr: 0, id: 8'h7F, len: 4'd15, wlast_beat: 0,  stall: 0, exp_beats: 16, exp_resp: 2'b11};
      vecs[6] = '{is_wr: 1, id: 8'hFF, len: 4'd15, wlast_beat: 15, stall: 1, exp_beats: 16, exp_resp: 2'b11};

      awid = '0; awaddr = '0; awlen = '0; awvalid = 0;
      wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 0;
      arid = '0; araddr = '0; arlen = '0; arvalid = 0; rready = 0;
      areset = 1'b1;
      tick();
      tick();
      chk("rst_awready", awready, 1);
      chk("rst_arready", arready, 1);
      chk("rst_wready", wready, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rlast", rlast, 0);
      chk("rst_bid", bid, 0);
      chk("rst_rid", rid, 0);
      chk("rst_bresp", bresp, 0);
      chk("rst_rresp", rresp, 0);
      chk("rst_rdata", rdata, 0);
      chk_errlog();
      areset = 1'b0;

      // Concurrent AW and AR accepted on the same edge.
      cc_awaddr = 32'hDEAD_0100;
      awid = 8'h01; awlen = 4'd2; awaddr = cc_awaddr; awvalid = 1;
      arid = 8'h02; arlen = 4'd2; araddr = 32'hBEEF_0200; arvalid = 1;
      tick();
      awvalid = 0;
      arvalid = 0;
      exp_err_cnt  = 2;
      exp_err_addr = cc_awaddr;
      chk_errlog();
      for (int b = 0; b < 3; b++) begin
         wvalid = 1;
         rready = 1;
         chk("cc_wready", wready, 1);
         chk("cc_rvalid", rvalid, 1);
         chk("cc_rid", rid, 8'h02);
         chk("cc_rlast", rlast, (b == 2));
         chk("cc_bvalid_early", bvalid, 0);
         tick();
      end
      wvalid = 0;
      rready = 0;
      chk("cc_bvalid", bvalid, 1);
      chk("cc_bid", bid, 8'h01);
      chk("cc_rvalid_done", rvalid, 0);
      chk("cc_arready", arready, 1);
      bready = 1;
      tick();
      bready = 0;
      chk("cc_awready", awready, 1);

      // Directed bursts from the vector table.
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].is_wr) do_write(vecs[i]);
         else do_read(vecs[i]);
      end

      // Reset during beat 2 of an 8-beat read.
      arid = 8'h3C; arlen = 4'd7; araddr = $urandom; arvalid = 1;
      tick();
      arvalid = 0;
      rready = 1;
      tick();
      tick();
      chk("rr_beat2_valid", rvalid, 1);
      chk("rr_beat2_last", rlast, 0);
      #2;
      areset = 1'b1;
      #1;
      chk("rr_rvalid_rst", rvalid, 0);
      chk("rr_arready_rst", arready, 1);
      chk("rr_rid_rst", rid, 0);
      rready = 0;
      exp_err_cnt  = 0;
      exp_err_addr = '0;
      chk_errlog();
      tick();
      areset = 1'b0;
      rv = '{is_wr: 0, id: 8'h09, len: 4'd0, wlast_beat: 0, stall: 0, exp_beats: 1, exp_resp: 2'b11};
      do_read(rv);

      // Randomized traffic from a clean reset.
      do_reset();
      random_run(600);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_default_slave.md
# axi_default_slave

AXI default (error) slave of the bus crossbar: terminates every transaction the address decoder routes to its default-slave port (addresses outside all mapped regions). It accepts write and read bursts with full AXI handshakes and answers each with DECERR, so a master never hangs on an unmapped address. It sits directly downstream of the decoder's `VALID_SDEFAULT`/`READY_SDEFAULT` pair, behind the crossbar slave-side mux.

## Interface
Clock and reset: one clock; reset is asynchronous and active-high.
- `ID_W`, 8, slave-side ID width (master ID plus crossbar tag)
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `LEN_W`, 4, burst length field width (beats = LEN+1)

Ports:
- `ACLK` in 1 — clock
- `ARESET` in 1 — async reset, active-high
- `AWID` / `AWADDR` / `AWLEN` in ID_W / ADDR_W / LEN_W — write address; AWSIZE, AWBURST accepted upstream and ignored here
- `AWVALID` in 1, `AWREADY` out 1 — write address handshake
- `WDATA` / `WSTRB` / `WLAST` in DATA_W / DATA_W/8 / 1 — write data, discarded
- `WVALID` in 1, `WREADY` out 1 — write data handshake
- `BID` out ID_W, `BRESP` out 2 — write response
- `BVALID` out 1, `BREADY` in 1 — write response handshake
- `ARID` / `ARADDR` / `ARLEN` in ID_W / ADDR_W / LEN_W — read address
- `ARVALID` in 1, `ARREADY` out 1 — read address handshake
- `RID` out ID_W, `RDATA` out DATA_W, `RRESP` out 2, `RLAST` out 1
- `RVALID` out 1, `RREADY` in 1 — read data handshake
- `ERR_ADDR` out ADDR_W, `ERR_CNT` out 16 — present only with `AXI_DEFSLV_ERRLOG_EN`

## Operation
- Write and read paths are independent FSMs; both may be active simultaneously.
- Write FSM states W_IDLE, W_DATA, W_RESP. W_IDLE: AWREADY=1. AWVALID&AWREADY -> capture AWID, AWLEN, zero beat counter, go W_DATA.
- W_DATA: WREADY=1; each WVALID&WREADY increments counter; beat where counter==captured AWLEN -> W_RESP. WLAST is not used for termination.
- W_RESP: BVALID=1, BRESP=2'b11, BID=captured ID; BVALID&BREADY -> W_IDLE.
- Read FSM states R_IDLE, R_DATA. R_IDLE: ARREADY=1. ARVALID&ARREADY -> capture ARID, ARLEN, zero counter, go R_DATA.
- R_DATA: RVALID=1, RDATA=0, RRESP=2'b11, RID=captured ID, RLAST=(counter==captured ARLEN). RVALID&RREADY: if RLAST -> R_IDLE, else counter+1.
- Counters are LEN_W bits; max burst 2^LEN_W beats, no wrap possible.
- Outside their states, BRESP/RRESP/RID/BID/RDATA drive 0.

## Timing
- Reset values: AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0, BID=RID=0, BRESP=RRESP=0, RDATA=0, ERR_ADDR=0, ERR_CNT=0.
- All outputs are functions of registered state only; no combinational path from any input to any output.
- Write latency: AW handshake at cycle N -> WREADY at N+1; last W beat at M -> BVALID at M+1.
- Read latency: AR handshake at N -> first RVALID at N+1; one beat per cycle while RREADY=1.
- One outstanding transaction per direction; AWREADY/ARREADY low from accept until return to IDLE, so back-to-back bursts have a one-cycle gap.
- VALID held with READY low: outputs stable, no state change.
- ARESET mid-burst: immediate return to IDLE, in-flight transaction dropped, no response issued.

## Configuration
- `AXI_DEFSLV_ERRLOG_EN` defined: `ERR_ADDR` and `ERR_CNT` ports exist; each AW or AR handshake loads ERR_ADDR with AWADDR/ARADDR and increments ERR_CNT (saturating at 16'hFFFF). Same-cycle AW and AR accept: ERR_ADDR takes AWADDR, ERR_CNT +2 (saturating).
- Not defined: ports and registers absent; AWADDR/ARADDR unused.

## Structure
- Shared AXI package holds width constants, `RESP_DECERR = 2'b11`, `RESP_OKAY`, and the FSM state enums.
- Optional sub-module `axi_defslv_errlog` for the ERR_ADDR/ERR_CNT logic, instantiated under the macro; read and write FSMs stay in the top module.

## Test plan
- Single write: AWID=8'h15, AWLEN=0, one W beat, BREADY=1 -> BVALID one cycle after W beat, BID=8'h15, BRESP=2'b11, back to AWREADY=1.
- Read burst: ARID=8'h2A, ARLEN=3, RREADY=1 -> 4 consecutive RVALID beats, RDATA=0, RRESP=2'b11, RLAST only on 4th, RID=8'h2A.
- Backpressure: ARLEN=1, RREADY toggled 0/1 every cycle -> RDATA/RLAST stable while stalled, exactly 2 beats delivered; BREADY held 0 for 5 cycles -> BVALID stays high, BID unchanged.
- Concurrent: AW (ID 1, len 2) and AR (ID 2, len 2) in same cycle -> both complete independently with correct IDs; with macro ERR_CNT=2, ERR_ADDR=AWADDR.
- Reset mid-read: ARESET asserted during beat 2 of ARLEN=7 -> RVALID=0 immediately, ARREADY=1, next ARLEN=0 read returns single RLAST beat.
- WLAST mismatch: AWLEN=2, WLAST asserted on beat 1 -> FSM still takes 3 beats before BVALID.
